usb_pd_uart_sched: RTL and testbench

- Shares the single UART transmitter between NUM_SRC character producers: the PD decoder char stream, status/timestamp message generators, and similar sources.
- Each source writes bytes into its own FIFO. A round-robin scheduler pops bytes and drives the UART send_trig/send_data, pacing each byte on tx_bsy.
- Line lock: once a source starts a line, it keeps the UART until it sends a byte marked last, so text lines never interleave.

---
 rtl/usb_pd_uart_sched.sv | 208 ++++++++++++++++++++
 tb/tb_usb_pd_uart_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_pd_uart_sched.sv
// rtl/usb_pd_uart_sched.sv - per-source byte FIFOs and a round-robin, line-locked scheduler for one shared UART transmitter

module usb_pd_uart_sched_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_tvalid,
  input  logic [8:0] wr_tdata,
  input  logic       rd_pop,
  output logic [8:0] rd_tdata,
  output logic       rd_tvalid,
  output logic       full,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign rd_tvalid = (count_q != '0);
  assign rd_tdata  = mem_q[rptr_q];
  assign pop       = rd_pop && rd_tvalid;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push      = wr_tvalid && (!full || pop);
  assign drop      = wr_tvalid && !push;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_tdata;
  end
endmodule

module usb_pd_uart_sched #(
  parameter int NUM_SRC     = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int BSY_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [8*NUM_SRC-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_full,
  output logic [NUM_SRC-1:0]         ovf_flag,
  input  logic                       ovf_clr,
  output logic                       send_trig,
  output logic [7:0]                 send_data,
  input  logic                       tx_bsy,
  output logic                       tx_err,
  output logic [$clog2(NUM_SRC)-1:0] grant
);
  localparam int GW   = $clog2(NUM_SRC);
  localparam int CNTW = $clog2(BSY_TIMEOUT);
  localparam logic [GW:0]     NUM_SRC_W = (GW + 1)'(NUM_SRC);
  localparam logic [CNTW-1:0] TO_LAST   = CNTW'(BSY_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_TRIG      = 2'd1;
  localparam logic [1:0] ST_WAIT_BSY  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               lock_q, lock_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               send_trig_q, send_trig_d;
  logic [7:0]         send_data_q, send_data_d;
  logic [NUM_SRC-1:0] ovf_q, ovf_d;
  logic               tx_err_q, tx_err_d;

  logic [8:0]         head [NUM_SRC];
  logic [NUM_SRC-1:0] nonempty, drop, pop_vec;
  logic               sel_found;
  logic [GW-1:0]      sel_idx;
  logic [GW:0]        cand;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    usb_pd_uart_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_tvalid (src_valid[i]),
      .wr_tdata  ({src_last[i], src_data[8*i +: 8]}),
      .rd_pop    (pop_vec[i]),
      .rd_tdata  (head[i]),
      .rd_tvalid (nonempty[i]),
      .full      (src_full[i]),
      .drop      (drop[i])
    );
  end

  // Search starts one past the last grant; the last grant itself is tried last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant_q;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, grant_q} + (GW + 1)'(k);
      if (cand >= NUM_SRC_W) cand = cand - NUM_SRC_W;
      if (!sel_found && nonempty[cand[GW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lock_d      = lock_q;
    cnt_d       = cnt_q;
    send_trig_d = 1'b0;
    send_data_d = send_data_q;
    ovf_d       = (ovf_clr ? '0 : ovf_q) | drop;
    tx_err_d    = ovf_clr ? 1'b0 : tx_err_q;
    pop_vec     = '0;
    case (state_q)
      ST_IDLE: begin
        if (lock_q) begin
          if (nonempty[grant_q]) begin
            state_d     = ST_TRIG;
            send_trig_d = 1'b1;
            send_data_d = head[grant_q][7:0];
          end
        end else if (sel_found) begin
          grant_d     = sel_idx;
          state_d     = ST_TRIG;
          send_trig_d = 1'b1;
          send_data_d = head[sel_idx][7:0];
        end
      end
      ST_TRIG: begin
        pop_vec[grant_q] = 1'b1;
        lock_d           = ~head[grant_q][8];
        cnt_d            = CNTW'(1);
        state_d          = ST_WAIT_BSY;
      end
      // cnt_q counts cycles since send_trig, so tx_err lands BSY_TIMEOUT cycles after it.
      ST_WAIT_BSY: begin
        if (tx_bsy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          tx_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_bsy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
      send_trig_q <= 1'b0;
      send_data_q <= '0;
      ovf_q       <= '0;
      tx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
      send_trig_q <= send_trig_d;
      send_data_q <= send_data_d;
      ovf_q       <= ovf_d;
      tx_err_q    <= tx_err_d;
    end
  end

  assign send_trig = send_trig_q;
  assign send_data = send_data_q;
  assign ovf_flag  = ovf_q;
  assign tx_err    = tx_err_q;
  assign grant     = grant_q;
endmodule

// File: tb/tb_usb_pd_uart_sched.sv
// tb/tb_usb_pd_uart_sched.sv - scoreboard bench for usb_pd_uart_sched with a simple UART busy model

module tb_usb_pd_uart_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [1:0]  src_last;
  logic [1:0]  src_full;
  logic [1:0]  ovf_flag;
  logic        ovf_clr;
  logic        send_trig;
  logic [7:0]  send_data;
  logic        tx_bsy;
  logic        tx_err;
  logic [0:0]  grant;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          trig_count = 0;
  int          last_trig_cyc = 0;
  logic [7:0]  exp_q[$];
  bit          uart_force_hi = 1'b0;
  bit          uart_respond = 1'b1;

  usb_pd_uart_sched #(.NUM_SRC(2), .FIFO_DEPTH(16), .BSY_TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_full  (src_full),
    .ovf_flag  (ovf_flag),
    .ovf_clr   (ovf_clr),
    .send_trig (send_trig),
    .send_data (send_data),
    .tx_bsy    (tx_bsy),
    .tx_err    (tx_err),
    .grant     (grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART model: busy from one cycle after each trigger, for 10 cycles.
  initial begin
    int bsy_cnt;
    bsy_cnt = 0;
    tx_bsy = 1'b0;
    forever @(negedge clk) begin
      if (uart_force_hi) tx_bsy = 1'b1;
      else if (bsy_cnt > 0) begin tx_bsy = 1'b1; bsy_cnt--; end
      else tx_bsy = 1'b0;
      if (send_trig === 1'b1 && uart_respond) bsy_cnt = 10;
    end
  end

  initial begin
    logic [7:0] e;
    forever @(negedge clk) begin
      if (send_trig === 1'b1) begin
        trig_count++;
        last_trig_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_trig", 32'(send_data), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("send_data", 32'(send_data), 32'(e));
        end
      end
    end
  end

  task automatic push1(input int s, input logic [7:0] d, input logic l);
    src_valid = '0;
    src_valid[s] = 1'b1;
    src_data[8*s +: 8] = d;
    src_last[s] = l;
    @(negedge clk);
    src_valid = '0;
    src_last = '0;
  endtask

  task automatic wait_trig(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (send_trig === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (15) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base;
    rst = 1'b1; src_valid = '0; src_data = '0; src_last = '0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send_trig", 32'(send_trig), 32'd0);
    check("rst_send_data", 32'(send_data), 32'd0);
    check("rst_src_full", 32'(src_full), 32'd0);
    check("rst_ovf_flag", 32'(ovf_flag), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: trigger two cycles after the push.
    exp_q.push_back(8'h41);
    t = cyc;
    push1(0, 8'h41, 1'b1);
    wait_trig("single_trig", 10);
    check("single_latency", 32'(last_trig_cyc - t), 32'd2);
    drain("single_drain", 40);
    check("single_grant", 32'(grant), 32'd0);
    check("single_lock", 32'(dut.lock_q), 32'd0);

    // Round-robin starting from grant=0.
    base = trig_count;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'hB0 + 8'(k));
      exp_q.push_back(8'hA0 + 8'(k));
    end
    for (int k = 0; k < 3; k++) begin
      src_valid = 2'b11;
      src_data = {8'hB0 + 8'(k), 8'hA0 + 8'(k)};
      src_last = 2'b11;
      @(negedge clk);
    end
    src_valid = '0; src_last = '0;
    drain("rr_drain", 200);
    check("rr_trig_count", 32'(trig_count - base), 32'd6);

    // Line lock: src1's byte must wait for the end of src0's line.
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h78);
    push1(0, 8'h41, 1'b0);
    push1(0, 8'h42, 1'b0);
    repeat (3) @(negedge clk);
    push1(1, 8'h78, 1'b1);
    repeat (16) @(negedge clk);
    check("lock_held", 32'(dut.lock_q), 32'd1);
    push1(0, 8'h0A, 1'b1);
    drain("lock_drain", 200);

    // Timeout: UART never goes busy.
    uart_respond = 1'b0;
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    push1(0, 8'h55, 1'b1);
    push1(0, 8'h66, 1'b1);
    wait_trig("to_first_trig", 10);
    t = cyc;
    repeat (63) @(negedge clk);
    check("to_err_before", 32'(tx_err), 32'd0);
    @(negedge clk);
    check("to_err_at", 32'(tx_err), 32'd1);
    check("to_state_idle", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    wait_trig("to_second_trig", 10);
    check("to_next_trig_gap", 32'(cyc - t), 32'd65);
    repeat (70) @(negedge clk);
    check("to_err_again", 32'(tx_err), 32'd1);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    check("to_err_clr", 32'(tx_err), 32'd0);
    uart_respond = 1'b1;
    check("to_drain", 32'(exp_q.size()), 32'd0);

    // Overflow while the scheduler is parked in WAIT_DONE.
    uart_force_hi = 1'b1;
    exp_q.push_back(8'h31);
    push1(1, 8'h31, 1'b1);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back(8'h60 + 8'(k));
      push1(0, 8'h60 + 8'(k), 1'b1);
    end
    check("ovf_not_full_15", 32'(src_full[0]), 32'd0);
    exp_q.push_back(8'h6F);
    push1(0, 8'h6F, 1'b1);
    check("ovf_full_16", 32'(src_full[0]), 32'd1);
    check("ovf_flag_16", 32'(ovf_flag[0]), 32'd0);
    push1(0, 8'h70, 1'b1);
    check("ovf_flag_17", 32'(ovf_flag[0]), 32'd1);
    ovf_clr = 1'b1;
    push1(0, 8'h71, 1'b1);
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf_flag[0]), 32'd1);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_flag[0]), 32'd0);
    uart_force_hi = 1'b0;
    wait_trig("ovf_pop_trig", 40);
    exp_q.push_back(8'h7E);
    push1(0, 8'h7E, 1'b1);
    check("ovf_push_pop_full", 32'(src_full[0]), 32'd1);
    check("ovf_push_pop_flag", 32'(ovf_flag[0]), 32'd0);
    drain("ovf_drain", 400);

    // Reset during WAIT_DONE with bytes still queued.
    exp_q.push_back(8'h90); exp_q.push_back(8'h91); exp_q.push_back(8'h92);
    push1(1, 8'h90, 1'b1);
    push1(1, 8'h91, 1'b1);
    push1(1, 8'h92, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (dut.state_q == 2'd3) break;
      @(negedge clk);
    end
    check("mid_wait_done", 32'(dut.state_q), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_trig", 32'(send_trig), 32'd0);
    check("mid_rst_data", 32'(send_data), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_full", 32'(src_full), 32'd0);
    check("mid_rst_err", 32'(tx_err), 32'd0);
    check("mid_rst_fifo1", 32'(dut.g_src[1].u_fifo.count_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    base = trig_count;
    repeat (40) @(negedge clk);
    check("mid_no_trig", 32'(trig_count - base), 32'd0);
    exp_q.push_back(8'hA5);
    push1(0, 8'hA5, 1'b1);
    drain("mid_after_drain", 40);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
